irq_arbiter: RTL

Collects single-cycle interrupt pulses from the timer blocks and the other peripherals into latched flags. It arbitrates the pending, enabled sources by group priority and presents one request, with its vector and level, to the CPU. It shares the CPU's single interrupt input among 16 sources and is configured through the same byte-wide I/O bus used by the timer registers.

---
 rtl/irq_arbiter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/irq_arbiter.sv
// Interrupt arbiter: latches 16 interrupt pulses into flags and arbitrates the enabled ones
// by group priority. It presents one request, vector and level to the CPU.
module irq_arbiter #(
    parameter logic [23:0] IRQ_PRI = 24'h2020,
    parameter logic [23:0] IRQ_ENA = 24'h2023,
    parameter logic [23:0] IRQ_ACT = 24'h2027
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_ce,
    input  logic        bus_write,
    input  logic        bus_read,
    input  logic [23:0] bus_address_in,
    input  logic [7:0]  bus_data_in,
    output logic [7:0]  bus_data_out,
    input  logic [15:0] irq_in,
    input  logic [1:0]  cpu_mask,
    input  logic        irq_ack,
    output logic        irq_req,
    output logic [3:0]  irq_vector,
    output logic [1:0]  irq_level
);

    typedef enum logic [1:0] {StIdle, StReq, StAck} state_e;

    state_e      state_q, state_d;
    logic [7:0]  pri_q, pri_d;
    logic [15:0] ena_q, ena_d;
    logic [15:0] act_q, act_d;
    logic        req_q, req_d;
    logic [3:0]  vec_q, vec_d;
    logic [1:0]  lvl_q, lvl_d;

    logic [15:0] elig;
    logic [15:0] clr;
    logic        any_elig;
    logic [3:0]  win_vec;
    logic [1:0]  win_lvl;

    // Strict '>' while scanning upwards keeps the lowest index on equal levels.
    always_comb begin
        elig     = '0;
        win_vec  = '0;
        win_lvl  = '0;
        any_elig = 1'b0;
        for (int i = 0; i < 16; i++) begin
            logic [1:0] p;
            p = pri_q[2*(i/4) +: 2];
            elig[i] = act_q[i] && ena_q[i] && (p != 2'd0) && (p > cpu_mask);
            if (elig[i] && (p > win_lvl)) begin
                win_lvl = p;
                win_vec = 4'(i);
            end
        end
        any_elig = |elig;
    end

    always_comb begin
        pri_d = pri_q;
        ena_d = ena_q;
        clr   = '0;
        if (bus_write) begin
            if (bus_address_in == IRQ_PRI)         pri_d        = bus_data_in;
            if (bus_address_in == IRQ_ENA)         ena_d[7:0]   = bus_data_in;
            if (bus_address_in == IRQ_ENA + 24'd1) ena_d[15:8]  = bus_data_in;
            if (bus_address_in == IRQ_ACT)         clr[7:0]     = bus_data_in;
            if (bus_address_in == IRQ_ACT + 24'd1) clr[15:8]    = bus_data_in;
        end
        if (state_q == StReq && irq_ack) clr[vec_q] = 1'b1;
        // New pulses win over any clear in the same cycle.
        act_d = (act_q & ~clr) | irq_in;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (any_elig) state_d = StReq;
            StReq: begin
                if (irq_ack)        state_d = StAck;
                else if (!any_elig) state_d = StIdle;
            end
            StAck:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
        req_d = (state_d == StReq);
        vec_d = any_elig ? win_vec : vec_q;
        lvl_d = any_elig ? win_lvl : lvl_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            pri_q   <= '0;
            ena_q   <= '0;
            act_q   <= '0;
            req_q   <= 1'b0;
            vec_q   <= '0;
            lvl_q   <= '0;
        end else if (clk_ce) begin
            state_q <= state_d;
            pri_q   <= pri_d;
            ena_q   <= ena_d;
            act_q   <= act_d;
            req_q   <= req_d;
            vec_q   <= vec_d;
            lvl_q   <= lvl_d;
        end
    end

    always_comb begin
        bus_data_out = 8'h00;
        if (bus_read) begin
            if (bus_address_in == IRQ_PRI)         bus_data_out = pri_q;
            if (bus_address_in == IRQ_ENA)         bus_data_out = ena_q[7:0];
            if (bus_address_in == IRQ_ENA + 24'd1) bus_data_out = ena_q[15:8];
            if (bus_address_in == IRQ_ACT)         bus_data_out = act_q[7:0];
            if (bus_address_in == IRQ_ACT + 24'd1) bus_data_out = act_q[15:8];
        end
    end

    assign irq_req    = req_q;
    assign irq_vector = vec_q;
    assign irq_level  = lvl_q;

endmodule
